// File: rtl/cips_sequencer.sv
// Fetch/execute sequencer for a small ALU program: fetches 11-bit instructions,
// drives an external ALU and hands each ALU result out over a valid/ready port.
module cips_sequencer #(
    parameter logic [7:0] START_ADDR = 8'h00,
    parameter logic [7:0] LAST_ADDR  = 8'hFF
) (
    input  logic        clk,
    input  logic        R,
    input  logic        start,
    input  logic        abort,
    output logic [7:0]  imem_addr,
    input  logic [10:0] imem_data,
    output logic [2:0]  alu_ctrl,
    output logic [3:0]  alu_x,
    output logic [3:0]  alu_y,
    input  logic [4:0]  alu_result,
    output logic [4:0]  result,
    output logic        result_valid,
    input  logic        result_ready,
    output logic        busy,
    output logic        done,
    output logic [7:0]  pc,
    output logic [8:0]  instr_count
);

    typedef enum logic [2:0] {IDLE, FETCH, EXEC, OUT, DONE} state_t;

    state_t      state_q, state_d;
    logic [7:0]  pc_q, pc_d;
    logic [8:0]  cnt_q, cnt_d;
    logic [10:0] ir_q, ir_d;
    logic [4:0]  res_q, res_d;
    logic        vld_q, vld_d;

    state_t      state_adv;
    logic [7:0]  pc_adv;
    logic [8:0]  cnt_inc;

    always_ff @(posedge clk or negedge R) begin
        if (!R) begin
            state_q <= IDLE;
            pc_q    <= START_ADDR;
            cnt_q   <= '0;
            ir_q    <= '0;
            res_q   <= '0;
            vld_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
            ir_q    <= ir_d;
            res_q   <= res_d;
            vld_q   <= vld_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        cnt_d   = cnt_q;
        ir_d    = ir_q;
        res_d   = res_q;
        vld_d   = vld_q;

        // Program end stops on LAST_ADDR with pc left pointing at it.
        state_adv = (pc_q == LAST_ADDR) ? DONE : FETCH;
        pc_adv    = (pc_q == LAST_ADDR) ? pc_q : pc_q + 8'd1;
        cnt_inc   = (cnt_q == 9'h1FF) ? cnt_q : cnt_q + 9'd1;

        if (abort && busy) begin
            state_d = IDLE;
            vld_d   = 1'b0;
        end else begin
            case (state_q)
                IDLE: if (start) begin
                    pc_d    = START_ADDR;
                    cnt_d   = '0;
                    state_d = FETCH;
                end
                FETCH: begin
                    ir_d    = imem_data;
                    state_d = EXEC;
                end
                EXEC: begin
                    if (ir_q[10:8] <= 3'd4) begin
                        res_d   = alu_result;
                        vld_d   = 1'b1;
                        cnt_d   = cnt_inc;
                        state_d = OUT;
                    end else if (ir_q[10:8] != 3'd7) begin
                        cnt_d   = cnt_inc;
                        pc_d    = pc_adv;
                        state_d = state_adv;
                    end else begin
                        state_d = DONE;
                    end
                end
                OUT: if (vld_q && result_ready) begin
                    vld_d   = 1'b0;
                    pc_d    = pc_adv;
                    state_d = state_adv;
                end
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    assign busy         = (state_q == FETCH) || (state_q == EXEC) || (state_q == OUT);
    assign done         = (state_q == DONE);
    assign imem_addr    = pc_q;
    assign pc           = pc_q;
    assign instr_count  = cnt_q;
    assign alu_ctrl     = ir_q[10:8];
    assign alu_x        = ir_q[7:4];
    assign alu_y        = ir_q[3:0];
    assign result       = res_q;
    assign result_valid = vld_q;

endmodule

// File: doc/cips_sequencer.md
CIPS_SEQUENCER -- requirements
Module: cips_sequencer

Interface
REQ-001 SHALL have parameter START_ADDR, default 8'h00, meaning the first instruction address fetched after start.
REQ-002 SHALL have parameter LAST_ADDR, default 8'hFF, meaning the last address executed before the program ends without a HALT.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port R  input  1  reset, asynchronous, active-low (R=0 resets).
REQ-005 SHALL have port start  input  1  begin program run; sampled in IDLE only.
REQ-006 SHALL have port abort  input  1  synchronous abort of a run in progress.
REQ-007 SHALL have port imem_addr  output  8  instruction memory address (equals pc).
REQ-008 SHALL have port imem_data  input  11  combinational instruction read data: [10:8] op, [7:4] x, [3:0] y.
REQ-009 SHALL have ports alu_ctrl (output, 3), alu_x (output, 4) and alu_y (output, 4), which drive the ALU.
REQ-010 SHALL have port alu_result  input  5  combinational ALU output.
REQ-011 SHALL have port result  output  5  registered result of the last executed ALU instruction.
REQ-012 SHALL have port result_valid  output  1  result holds an unconsumed value.
REQ-013 SHALL have port result_ready  input  1  consumer accepts result when result_valid=1 and result_ready=1.
REQ-014 SHALL have ports busy (output, 1), done (output, 1), pc (output, 8) and instr_count (output, 9).

Function
REQ-015 SHALL implement states IDLE, FETCH, EXEC, OUT and DONE; busy=1 in FETCH, EXEC and OUT, and busy=0 otherwise.
REQ-016 SHALL, in IDLE with start=1, load pc<=START_ADDR, clear instr_count to 0 and go to FETCH; start SHALL be ignored in all other states.
REQ-017 SHALL, in FETCH, drive imem_addr=pc, register imem_data into an instruction register and go to EXEC; this takes exactly 1 cycle.
REQ-018 SHALL drive alu_ctrl, alu_x and alu_y from the instruction register at all times, with value 0 after reset.
REQ-019 SHALL, in EXEC with op 000-100 (ALU op), capture alu_result into result, set result_valid=1, increment instr_count and go to OUT.
REQ-020 SHALL, in EXEC with op 101 or 110 (NOP), leave result and result_valid unchanged, increment instr_count and advance as in REQ-022.
REQ-021 SHALL, in EXEC with op 111 (HALT), go to DONE without incrementing instr_count.
REQ-022 SHALL advance a run as follows: if pc==LAST_ADDR go to DONE; otherwise set pc<=pc+1 (8-bit wrap) and go to FETCH.
REQ-023 SHALL, in OUT, hold result and result_valid stable until a handshake occurs.
REQ-024 SHALL, on a handshake in OUT, clear result_valid and advance as in REQ-022 in the same cycle.
REQ-025 SHALL give a steady-state throughput of 1 result per 3 cycles when result_ready is held at 1, with result_valid rising 2 cycles after the FETCH cycle begins.
REQ-026 SHALL, in DONE, assert done=1 for exactly one cycle and then return to IDLE; pc and instr_count SHALL hold their values until the next start.
REQ-027 SHALL let abort=1 in FETCH, EXEC or OUT force the next state to IDLE with result_valid<=0; abort SHALL take priority over every other transition, including a simultaneous handshake or HALT.
REQ-028 SHALL ignore abort in IDLE and DONE.
REQ-029 SHALL saturate instr_count at 9'h1FF.

Reset
REQ-030 SHALL, while R=0, asynchronously force state=IDLE, pc=START_ADDR, instr_count=0, instruction register=0, result=0, result_valid=0, done=0 and busy=0.
REQ-031 SHALL treat R=0 mid-run as an immediate return to IDLE with no done pulse; the first start after R returns to 1 SHALL restart the run from START_ADDR.

Verification
REQ-032 SHALL cover run-to-halt: memory[0]=000_0011_0101, memory[1]=111_xxxx_xxxx, start pulse, ready=1 -> result=5'd8 with a one-cycle valid, then a done pulse, instr_count=1, pc=1.
REQ-033 SHALL cover backpressure: memory[0]=001_0010_0011 with ready=0 for 5 cycles -> result=5'b11111 held stable with valid=1 for the 5 cycles, then advance one cycle after ready=1.
REQ-034 SHALL cover NOP: memory[0]=101_..., memory[1]=010_1010_0101, memory[2]=111 -> exactly one valid beat with result=5'd15, and instr_count=2.
REQ-035 SHALL cover end of program: LAST_ADDR=8'h02 with three ALU instructions and no HALT -> 3 results, done pulse, pc=2.
REQ-036 SHALL cover abort during OUT with ready=1 in the same cycle -> IDLE next cycle, valid=0, no done pulse, pc unchanged.
REQ-037 SHALL cover R=0 during EXEC -> all outputs at reset values immediately, without waiting for clk.
